// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: serialises instruction-fetch and data requests onto
// one downstream port and returns read data plus a one-cycle resp to the owner.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit RR_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_W-1:0]     imem_address,
  input  logic                  imem_read,
  output logic [DATA_W-1:0]     imem_rdata,
  output logic                  imem_resp,

  input  logic [ADDR_W-1:0]     dmem_address,
  input  logic                  dmem_read,
  input  logic                  dmem_write,
  input  logic [DATA_W/8-1:0]   dmem_wmask,
  input  logic [DATA_W-1:0]     dmem_wdata,
  output logic [DATA_W-1:0]     dmem_rdata,
  output logic                  dmem_resp,

  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_W/8-1:0]   mem_wmask,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    RESP_I,
    RESP_D
  } state_t;

  state_t state;
  logic   last_d;   // 1 when the most recent completed grant went to dmem
  logic   d_write;  // captured store/load kind of the active dmem grant
  logic   i_pend;
  logic   d_pend;
  logic   pick_d;

  // NOTE: always_comb assigns every output first, so no path can leave one unassigned (no latch).
  always_comb begin
    i_pend = imem_read;
    d_pend = dmem_read | dmem_write;
    pick_d = d_pend;
    if (RR_EN && i_pend && d_pend) pick_d = !last_d;
  end

  // The downstream address/mask/data registers double as the capture registers,
  // so requester inputs changing mid-grant cannot leak through.
  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_d      <= 1'b0;
      d_write     <= 1'b0;
      mem_address <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wmask   <= '0;
      mem_wdata   <= '0;
      imem_rdata  <= '0;
      imem_resp   <= 1'b0;
      dmem_rdata  <= '0;
      dmem_resp   <= 1'b0;
    end else begin
      imem_resp <= 1'b0;
      dmem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_d) begin
            state       <= GRANT_D;
            d_write     <= dmem_write;
            mem_address <= dmem_address;
            mem_wdata   <= dmem_wdata;
            mem_wmask   <= dmem_write ? dmem_wmask : '0;
            // A simultaneous read+write is treated as a store; the read is dropped.
            mem_write   <= dmem_write;
            mem_read    <= !dmem_write;
          end else if (i_pend) begin
            state       <= GRANT_I;
            mem_address <= imem_address;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
            mem_read    <= 1'b1;
            mem_write   <= 1'b0;
          end
        end
        GRANT_I: begin
          if (mem_resp) begin
            state      <= RESP_I;
            mem_read   <= 1'b0;
            imem_rdata <= mem_rdata;
            imem_resp  <= 1'b1;
          end
        end
        GRANT_D: begin
          if (mem_resp) begin
            state      <= RESP_D;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            dmem_rdata <= d_write ? '0 : mem_rdata;
            dmem_resp  <= 1'b1;
          end
        end
        RESP_I: begin
          state  <= IDLE;
          last_d <= 1'b0;
        end
        RESP_D: begin
          state  <= IDLE;
          last_d <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
